fetch_stage_ctrl: RTL and testbench

Fetch-stage responder to the pipeline hazard detector. It owns the PC register and the IF/ID pipeline register. It applies the detector's `pc_hold`, `ifid_hold` and `if_flush` requests and the ID-stage branch redirect, and it produces the bubble request for ID/EX. It also keeps saturating stall and flush counters, a sticky stall-timeout flag and a sticky protocol-error flag for debug.

---
 rtl/fetch_stage_ctrl_if.sv | 33 +++
 rtl/fetch_stage_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_fetch_stage_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_ctrl_if.sv
// Hazard-detector / branch / instruction-memory bundle seen by the fetch stage.
// The master drives hazard requests and memory data; the slave reports fetch state.
interface fetch_stage_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic              pc_hold;
  logic              ifid_hold;
  logic              if_flush;
  logic              branch_taken;
  logic [31:0]       branch_target;
  logic [31:0]       imem_instr;
  logic [31:0]       pc;
  logic [31:0]       ifid_instr;
  logic [31:0]       ifid_pc4;
  logic              ifid_valid;
  logic              idex_bubble;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  flush_count;
  logic              stall_timeout;
  logic              protocol_err;

  modport master (
    output pc_hold, ifid_hold, if_flush, branch_taken, branch_target, imem_instr,
    input  pc, ifid_instr, ifid_pc4, ifid_valid, idex_bubble,
           stall_cycles, flush_count, stall_timeout, protocol_err
  );

  modport slave (
    input  pc_hold, ifid_hold, if_flush, branch_taken, branch_target, imem_instr,
    output pc, ifid_instr, ifid_pc4, ifid_valid, idex_bubble,
           stall_cycles, flush_count, stall_timeout, protocol_err
  );
endinterface

// File: rtl/fetch_stage_ctrl.sv
// Fetch-stage controller: owns the PC and IF/ID register, applies hazard holds,
// flushes and branch redirects, and keeps saturating debug counters and flags.
module fetch_stage_ctrl #(
  parameter logic [31:0] PC_RESET    = 32'h0000_0000,
  parameter int unsigned STALL_LIMIT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input logic               clk,
  input logic               rst_n,
  fetch_stage_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  localparam logic [7:0]       LIMIT   = 8'(STALL_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  state_t           state_r;
  state_t           state_next_s;
  logic             active_s;

  logic [31:0]      pc_r;
  logic [31:0]      ifid_instr_r;
  logic [31:0]      ifid_pc4_r;
  logic             ifid_valid_r;
  logic [CNT_W-1:0] stall_cycles_r;
  logic [CNT_W-1:0] flush_count_r;
  logic [7:0]       consec_r;
  logic             stall_timeout_r;
  logic             protocol_err_r;

  logic [31:0]      pc_next_s;
  logic [31:0]      ifid_instr_next_s;
  logic [31:0]      ifid_pc4_next_s;
  logic             ifid_valid_next_s;
  logic [CNT_W-1:0] stall_cycles_next_s;
  logic [CNT_W-1:0] flush_count_next_s;
  logic [7:0]       consec_next_s;
  logic             stall_timeout_next_s;
  logic             protocol_err_next_s;

  logic [31:0]      pc_plus4_s;
  logic             stall_both_s;
  logic             flush_load_s;
  logic [8:0]       consec_inc_s;

  assign pc_plus4_s   = pc_r + 32'd4;
  assign stall_both_s = bus.pc_hold & bus.ifid_hold;
  // A branch seen while the PC is held is dropped; it is re-resolved after the stall.
  assign flush_load_s = (bus.branch_taken & ~bus.pc_hold) | bus.if_flush;
  assign consec_inc_s = {1'b0, consec_r} + 9'd1;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_BOOT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_BOOT:  state_next_s = ST_RUN;
      ST_RUN:   state_next_s = stall_both_s ? ST_STALL : ST_RUN;
      ST_STALL: state_next_s = stall_both_s ? ST_STALL : ST_RUN;
      default:  state_next_s = ST_BOOT;
    endcase
  end

  // FSM outputs: only RUN and STALL act on the hazard inputs
  always_comb begin
    active_s = 1'b0;
    case (state_r)
      ST_RUN:   active_s = 1'b1;
      ST_STALL: active_s = 1'b1;
      default:  active_s = 1'b0;
    endcase
  end

  // Next values for PC, IF/ID and debug state
  always_comb begin
    pc_next_s            = pc_r;
    ifid_instr_next_s    = ifid_instr_r;
    ifid_pc4_next_s      = ifid_pc4_r;
    ifid_valid_next_s    = ifid_valid_r;
    stall_cycles_next_s  = stall_cycles_r;
    flush_count_next_s   = flush_count_r;
    consec_next_s        = consec_r;
    stall_timeout_next_s = stall_timeout_r;
    protocol_err_next_s  = protocol_err_r;
    if (active_s) begin
      if (bus.pc_hold) begin
        pc_next_s = pc_r;
      end else if (bus.branch_taken) begin
        pc_next_s = bus.branch_target;
      end else begin
        pc_next_s = pc_plus4_s;
      end

      if (bus.ifid_hold) begin
        ifid_valid_next_s = ifid_valid_r;
      end else if (flush_load_s) begin
        ifid_instr_next_s  = 32'h0000_0000;
        ifid_pc4_next_s    = 32'h0000_0000;
        ifid_valid_next_s  = 1'b0;
        flush_count_next_s = sat_inc(flush_count_r);
      end else begin
        ifid_instr_next_s = bus.imem_instr;
        ifid_pc4_next_s   = pc_plus4_s;
        ifid_valid_next_s = 1'b1;
      end

      if (bus.pc_hold) begin
        stall_cycles_next_s = sat_inc(stall_cycles_r);
      end else begin
        stall_cycles_next_s = stall_cycles_r;
      end

      // Run length counts every cycle with both holds, including the RUN->STALL cycle.
      if (stall_both_s) begin
        if (consec_r >= LIMIT) begin
          consec_next_s = consec_r;
        end else begin
          consec_next_s = consec_inc_s[7:0];
        end
        stall_timeout_next_s = stall_timeout_r | (consec_inc_s >= {1'b0, LIMIT});
      end else begin
        consec_next_s        = 8'd0;
        stall_timeout_next_s = stall_timeout_r;
      end

      protocol_err_next_s = protocol_err_r | (bus.pc_hold ^ bus.ifid_hold);
    end else begin
      pc_next_s = pc_r;
    end
  end

  // Registered PC, IF/ID and debug state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r            <= PC_RESET;
      ifid_instr_r    <= 32'h0000_0000;
      ifid_pc4_r      <= 32'h0000_0000;
      ifid_valid_r    <= 1'b0;
      stall_cycles_r  <= {CNT_W{1'b0}};
      flush_count_r   <= {CNT_W{1'b0}};
      consec_r        <= 8'd0;
      stall_timeout_r <= 1'b0;
      protocol_err_r  <= 1'b0;
    end else begin
      pc_r            <= pc_next_s;
      ifid_instr_r    <= ifid_instr_next_s;
      ifid_pc4_r      <= ifid_pc4_next_s;
      ifid_valid_r    <= ifid_valid_next_s;
      stall_cycles_r  <= stall_cycles_next_s;
      flush_count_r   <= flush_count_next_s;
      consec_r        <= consec_next_s;
      stall_timeout_r <= stall_timeout_next_s;
      protocol_err_r  <= protocol_err_next_s;
    end
  end

  assign bus.pc            = pc_r;
  assign bus.ifid_instr    = ifid_instr_r;
  assign bus.ifid_pc4      = ifid_pc4_r;
  assign bus.ifid_valid    = ifid_valid_r;
  assign bus.stall_cycles  = stall_cycles_r;
  assign bus.flush_count   = flush_count_r;
  assign bus.stall_timeout = stall_timeout_r;
  assign bus.protocol_err  = protocol_err_r;
  // Combinational: a held flush (load-use) or a NOP in IF/ID both need a bubble.
  assign bus.idex_bubble   = (bus.if_flush & bus.ifid_hold) | ~ifid_valid_r;

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Self-checking bench for fetch_stage_ctrl: directed scenarios plus random
// hazard traffic compared against a cycle-level behavioural model.
module tb_fetch_stage_ctrl;

  localparam logic [31:0] PC_RST = 32'h0000_0100;
  localparam int          LIMIT  = 4;
  localparam int          CW     = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_stage_ctrl_if #(.CNT_W(CW)) bus();

  fetch_stage_ctrl #(.PC_RESET(PC_RST), .STALL_LIMIT(LIMIT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  logic [31:0] mem [0:1023];
  assign bus.imem_instr = mem[bus.pc[11:2]];

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  logic [31:0]   m_pc, m_instr, m_pc4;
  logic          m_valid, m_boot, m_tmo, m_perr;
  logic [CW-1:0] m_stalls, m_flushes;
  int            m_run;
  logic          exp_bubble, obs_bubble;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return mem[a[11:2]];
  endfunction

  task automatic model_reset();
    m_pc = PC_RST; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_boot = 1'b1;
    m_tmo = 1'b0; m_perr = 1'b0; m_stalls = '0; m_flushes = '0; m_run = 0;
  endtask

  task automatic model_step(input logic ph, input logic ih, input logic fl,
                            input logic bt, input logic [31:0] tgt);
    logic [31:0] npc;
    if (m_boot) begin
      m_boot = 1'b0;
    end else begin
      npc = ph ? m_pc : (bt ? tgt : m_pc + 32'd4);
      if (!ih) begin
        if ((bt && !ph) || fl) begin
          m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
          if (m_flushes != {CW{1'b1}}) m_flushes = m_flushes + 1'b1;
        end else begin
          m_instr = word_at(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
        end
      end
      if (ph && m_stalls != {CW{1'b1}}) m_stalls = m_stalls + 1'b1;
      if (ph != ih) m_perr = 1'b1;
      if (ph && ih) begin
        if (m_run < LIMIT) m_run = m_run + 1;
        if (m_run >= LIMIT) m_tmo = 1'b1;
      end else begin
        m_run = 0;
      end
      m_pc = npc;
    end
  endtask

  // One clock: drive inputs, sample the combinational bubble, advance DUT and model.
  task automatic apply(input logic ph, input logic ih, input logic fl,
                       input logic bt, input logic [31:0] tgt);
    bus.pc_hold = ph; bus.ifid_hold = ih; bus.if_flush = fl;
    bus.branch_taken = bt; bus.branch_target = tgt;
    #1;
    exp_bubble = (fl & ih) | ~m_valid;
    obs_bubble = bus.idex_bubble;
    model_step(ph, ih, fl, bt, tgt);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.pc_hold = 1'b0; bus.ifid_hold = 1'b0; bus.if_flush = 1'b0;
    bus.branch_taken = 1'b0; bus.branch_target = 32'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (bus.pc !== PC_RST || bus.ifid_valid !== 1'b0 || bus.ifid_instr !== 32'h0 || bus.ifid_pc4 !== 32'h0) begin
      miscompares++; $display("FAIL reset_values: pc=%h v=%b i=%h p4=%h", bus.pc, bus.ifid_valid, bus.ifid_instr, bus.ifid_pc4); end
    vectors++; if (bus.idex_bubble !== 1'b1 || bus.stall_cycles !== '0 || bus.flush_count !== '0 || bus.stall_timeout !== 1'b0 || bus.protocol_err !== 1'b0) begin
      miscompares++; $display("FAIL reset_debug: bub=%b sc=%h fc=%h to=%b pe=%b (want 1 0 0 0 0)", bus.idex_bubble, bus.stall_cycles, bus.flush_count, bus.stall_timeout, bus.protocol_err); end
    apply(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0400);   // ignored in BOOT
    vectors++; if (bus.pc !== 32'h100 || bus.ifid_valid !== 1'b0 || bus.protocol_err !== 1'b0) begin
      miscompares++; $display("FAIL boot_edge1: pc=%h v=%b pe=%b want 00000100 0 0", bus.pc, bus.ifid_valid, bus.protocol_err); end
    apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    vectors++; if (bus.ifid_instr !== word_at(32'h100) || bus.ifid_pc4 !== 32'h104 || bus.pc !== 32'h104 || bus.ifid_valid !== 1'b1) begin
      miscompares++; $display("FAIL boot_edge2: i=%h p4=%h pc=%h want %h 00000104 00000104", bus.ifid_instr, bus.ifid_pc4, bus.pc, word_at(32'h100)); end
  endtask

  task automatic test_straight();
    logic [31:0] prev;
    for (int k = 0; k < 5; k++) begin
      prev = bus.pc;
      apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      vectors++; if (bus.pc !== prev + 32'd4 || bus.ifid_pc4 !== bus.pc || obs_bubble !== 1'b0 || bus.ifid_instr !== word_at(prev)) begin
        miscompares++; $display("FAIL straight_%0d: pc=%h p4=%h bub=%b want pc=%h bub=0", k, bus.pc, bus.ifid_pc4, obs_bubble, prev + 32'd4); end
    end
  endtask

  task automatic test_load_use();
    logic [31:0] pc0, i0;
    logic [CW-1:0] sc0;
    pc0 = bus.pc; i0 = bus.ifid_instr; sc0 = bus.stall_cycles;
    apply(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    vectors++; if (obs_bubble !== 1'b1 || bus.pc !== pc0 || bus.ifid_instr !== i0 || bus.stall_cycles !== CW'(1)) begin
      miscompares++; $display("FAIL load_use: bub=%b pc=%h i=%h sc=%h want 1 %h %h 1", obs_bubble, bus.pc, bus.ifid_instr, bus.stall_cycles, pc0, i0); end
    apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    vectors++; if (bus.pc !== pc0 + 32'd4 || bus.ifid_instr !== word_at(pc0) || bus.stall_cycles !== sc0 + 1'b1) begin
      miscompares++; $display("FAIL load_use_resume: pc=%h i=%h want %h %h", bus.pc, bus.ifid_instr, pc0 + 32'd4, word_at(pc0)); end
  endtask

  task automatic test_branch();
    logic [CW-1:0] fc0;
    fc0 = bus.flush_count;
    apply(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200);
    vectors++; if (bus.pc !== 32'h200 || bus.ifid_valid !== 1'b0 || bus.ifid_instr !== 32'h0 || bus.flush_count !== fc0 + 1'b1) begin
      miscompares++; $display("FAIL branch_redirect: pc=%h v=%b fc=%h want 00000200 0 %h", bus.pc, bus.ifid_valid, bus.flush_count, fc0 + 1'b1); end
    apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    vectors++; if (bus.ifid_instr !== word_at(32'h200) || bus.ifid_valid !== 1'b1 || obs_bubble !== 1'b1) begin
      miscompares++; $display("FAIL branch_target: i=%h v=%b bub=%b want %h 1 1", bus.ifid_instr, bus.ifid_valid, obs_bubble, word_at(32'h200)); end
  endtask

  task automatic test_branch_in_stall();
    logic [31:0] pc0, i0;
    logic [CW-1:0] fc0;
    pc0 = bus.pc; i0 = bus.ifid_instr; fc0 = bus.flush_count;
    apply(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0300);
    vectors++; if (bus.pc !== pc0 || bus.ifid_instr !== i0 || bus.flush_count !== fc0) begin
      miscompares++; $display("FAIL branch_in_stall: pc=%h i=%h fc=%h want %h %h %h", bus.pc, bus.ifid_instr, bus.flush_count, pc0, i0, fc0); end
    apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_timeout();
    logic [31:0] pc0;
    vectors++; if (bus.protocol_err !== 1'b0) begin
      miscompares++; $display("FAIL perr_clean: got %b want 0", bus.protocol_err); end
    for (int k = 1; k <= LIMIT; k++) begin
      apply(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      vectors++; if (bus.stall_timeout !== (k >= LIMIT)) begin
        miscompares++; $display("FAIL timeout_edge%0d: got %b want %b", k, bus.stall_timeout, (k >= LIMIT)); end
    end
    apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    vectors++; if (bus.stall_timeout !== 1'b1) begin
      miscompares++; $display("FAIL timeout_sticky: got %b want 1", bus.stall_timeout); end
    pc0 = bus.pc;
    apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    vectors++; if (bus.protocol_err !== 1'b1 || bus.ifid_valid !== 1'b1 || bus.ifid_instr !== word_at(pc0) || bus.pc !== pc0) begin
      miscompares++; $display("FAIL protocol_err: pe=%b v=%b i=%h pc=%h want 1 1 %h %h", bus.protocol_err, bus.ifid_valid, bus.ifid_instr, bus.pc, word_at(pc0), pc0); end
  endtask

  task automatic test_saturation();
    do_reset();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 20; k++) apply(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    vectors++; if (bus.stall_cycles !== {CW{1'b1}}) begin
      miscompares++; $display("FAIL stall_sat: got %h want %h", bus.stall_cycles, {CW{1'b1}}); end
    for (int k = 0; k < 20; k++) apply(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    vectors++; if (bus.flush_count !== {CW{1'b1}} || bus.ifid_valid !== 1'b0) begin
      miscompares++; $display("FAIL flush_sat: fc=%h v=%b want %h 0", bus.flush_count, bus.ifid_valid, {CW{1'b1}}); end
  endtask

  task automatic test_reset_mid_stall();
    for (int k = 0; k < 6; k++) apply(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    vectors++; if (bus.stall_timeout !== m_tmo || bus.stall_cycles !== m_stalls) begin
      miscompares++; $display("FAIL pre_reset: to=%b sc=%h want %b %h", bus.stall_timeout, bus.stall_cycles, m_tmo, m_stalls); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (bus.pc !== PC_RST || bus.stall_timeout !== 1'b0 || bus.protocol_err !== 1'b0 || bus.stall_cycles !== '0 || bus.flush_count !== '0 || bus.ifid_valid !== 1'b0 || bus.idex_bubble !== 1'b1) begin
      miscompares++; $display("FAIL async_reset: pc=%h to=%b pe=%b sc=%h fc=%h v=%b bub=%b", bus.pc, bus.stall_timeout, bus.protocol_err, bus.stall_cycles, bus.flush_count, bus.ifid_valid, bus.idex_bubble); end
    do_reset();
  endtask

  task automatic test_random();
    logic ph, ih, fl, bt;
    logic [31:0] tgt;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      ph  = ($urandom_range(0, 3) == 0);
      ih  = ($urandom_range(0, 9) == 0) ? ~ph : ph;
      fl  = ($urandom_range(0, 6) == 0);
      bt  = ($urandom_range(0, 6) == 0);
      tgt = $urandom & 32'h0000_0FFC;
      apply(ph, ih, fl, bt, tgt);
      vectors++; if (obs_bubble !== exp_bubble) begin
        miscompares++; $display("FAIL rand_bubble_%0d: got %b want %b", k, obs_bubble, exp_bubble); end
      vectors++;
      if ({bus.pc, bus.ifid_instr, bus.ifid_pc4, bus.ifid_valid, bus.stall_cycles, bus.flush_count, bus.stall_timeout, bus.protocol_err}
          !== {m_pc, m_instr, m_pc4, m_valid, m_stalls, m_flushes, m_tmo, m_perr}) begin
        miscompares++;
        $display("FAIL rand_state_%0d: got pc=%h i=%h p4=%h v=%b sc=%h fc=%h to=%b pe=%b want pc=%h i=%h p4=%h v=%b sc=%h fc=%h to=%b pe=%b",
                 k, bus.pc, bus.ifid_instr, bus.ifid_pc4, bus.ifid_valid, bus.stall_cycles, bus.flush_count, bus.stall_timeout, bus.protocol_err,
                 m_pc, m_instr, m_pc4, m_valid, m_stalls, m_flushes, m_tmo, m_perr);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = $urandom;
    test_reset();
    test_straight();
    test_load_use();
    test_branch();
    test_branch_in_stall();
    test_timeout();
    test_saturation();
    test_reset_mid_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
